eth_dma_scheduler: RTL and testbench
====================================

Name: eth_dma_scheduler

Overview:
- Sequences the shared dma_transfer engine and its mem_burst_in/mem_burst_out buffer ports between two requesters:
  - RX path: a received frame is written from the rx buffer to system memory.
  - TX path: a frame is read from system memory into the tx buffer.
- Arbitrates round-robin between the two requesters.
- Splits each request into chunks of at most MAX_CHUNK words and issues one DMA start per chunk.
- Pulses a per-path done when the whole request has been moved.

Parameters:
- AXI_ADDR_W, 32, byte address width of system memory.
- LEN_W, 16, width of word-count fields.
- BUF_ADDR_W, 11, word address width of the rx/tx buffers.
- MAX_CHUNK, 256, maximum words per DMA start; must be ≥1 and < 2^LEN_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_req_valid  in  1  RX request pending
- rx_req_ready  out  1  RX request accepted this cycle
- rx_req_addr  in  AXI_ADDR_W  memory byte address (word aligned)
- rx_req_len  in  LEN_W  words to move
- rx_done  out  1  one-cycle pulse, RX request complete
- tx_req_valid  in  1  TX request pending
- tx_req_ready  out  1  TX request accepted this cycle
- tx_req_addr  in  AXI_ADDR_W  memory byte address (word aligned)
- tx_req_len  in  LEN_W  words to move
- tx_done  out  1  one-cycle pulse, TX request complete
- dma_addr  out  AXI_ADDR_W  to dma_transfer addr
- dma_len  out  LEN_W  to dma_transfer length
- dma_read_not_write  out  1  1 = TX (memory read), 0 = RX (memory write)
- dma_start  out  1  one-cycle start pulse
- dma_ready  in  1  dma_transfer idle
- buf_start_addr  out  BUF_ADDR_W  start_addr for both burst units
- burst_out_start  out  1  start pulse to mem_burst_out (RX chunks)
- burst_in_start  out  1  start pulse to mem_burst_in (TX chunks)
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any time, including mid-transfer):
  - State goes to IDLE; all outputs are 0.
  - remaining, cur_addr and buf_ptr clear.
  - last_grant = TX, so the first contended grant goes to RX.
  - The in-flight request is dropped and no done is pulsed.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE arbitration:
  - rx_req_ready = IDLE & rx_req_valid & (!tx_req_valid | last_grant==TX).
  - tx_req_ready = IDLE & tx_req_valid & (!rx_req_valid | last_grant==RX).
  - Both ready signals are combinational; at most one is high.
- On accept:
  - Latch addr into cur_addr, len into remaining, direction into dir; set buf_ptr=0; update last_grant.
  - If len==0: stay IDLE and pulse that path's done on the next cycle. No DMA start.
  - Otherwise go to ISSUE.
- ISSUE:
  - Wait until dma_ready=1.
  - Then, for exactly one cycle, assert:
    - dma_start;
    - burst_out_start (dir=RX) or burst_in_start (dir=TX);
    - dma_addr=cur_addr, dma_len=chunk, buf_start_addr=buf_ptr, dma_read_not_write=(dir==TX).
  - chunk = min(remaining, MAX_CHUNK). Go to WAIT_BUSY.
  - dma_addr, dma_len and dma_read_not_write hold their values until the next ISSUE.
- WAIT_BUSY:
  - Wait for dma_ready=0, then go to WAIT_DONE.
  - Handles the engine dropping ready one or more cycles after start.
- WAIT_DONE: on dma_ready=1, update counters:
  - remaining -= chunk
  - cur_addr += chunk*4 (wraps modulo 2^AXI_ADDR_W)
  - buf_ptr += chunk (wraps modulo 2^BUF_ADDR_W)
  - If new remaining==0: pulse done for dir (one cycle, registered) and go to IDLE.
  - Else go to ISSUE.
- Latency:
  - Accept to first dma_start is 1 cycle if dma_ready is already 1.
  - Last chunk dma_ready rise to done pulse is 1 cycle.
- A new request can be accepted in the cycle following done (back-to-back allowed).
- Requests presented while busy are held off with ready=0. Requesters keep valid high and may not change addr/len until accepted.
- chunk arithmetic is done in LEN_W bits; MAX_CHUNK is compared unsigned.

Test Plan:
- Single RX, addr=0x100, len=100:
  - One dma_start with dma_len=100, dma_addr=0x100, dma_read_not_write=0, burst_out_start=1, buf_start_addr=0.
  - rx_done 1 cycle after dma_ready returns.
- Single TX, addr=0x0, len=1000, MAX_CHUNK=256:
  - Four starts with lengths 256,256,256,232.
  - dma_addr 0x0,0x400,0x800,0xC00; buf_start_addr 0,256,512,768.
  - burst_in_start each time; one tx_done.
- Simultaneous rx/tx valid after reset:
  - RX granted first, then TX.
  - Repeat with both valid: grants alternate RX,TX,RX,TX.
- len=0 on TX:
  - tx_req_ready pulse, tx_done next cycle.
  - No dma_start; busy stays 0.
- dma_ready delayed low by 3 cycles after start, then held low 50 cycles:
  - No second start until dma_ready rises.
  - Counters advance exactly once per chunk.
- Assert rst during the WAIT_DONE of the second chunk:
  - All outputs 0 immediately, no done pulse.
  - After release, a fresh RX request is served starting at buf_start_addr=0.

Source files
------------

// File: rtl/eth_dma_scheduler_if.sv
// Request, DMA-engine and burst-unit signals of the Ethernet DMA scheduler.
// The master modport is the scheduler; the slave modport is its surroundings.
interface eth_dma_scheduler_if #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned BUF_ADDR_W = 11
);
    logic                  rx_req_valid;
    logic                  rx_req_ready;
    logic [AXI_ADDR_W-1:0] rx_req_addr;
    logic [LEN_W-1:0]      rx_req_len;
    logic                  rx_done;

    logic                  tx_req_valid;
    logic                  tx_req_ready;
    logic [AXI_ADDR_W-1:0] tx_req_addr;
    logic [LEN_W-1:0]      tx_req_len;
    logic                  tx_done;

    logic [AXI_ADDR_W-1:0] dma_addr;
    logic [LEN_W-1:0]      dma_len;
    logic                  dma_read_not_write;
    logic                  dma_start;
    logic                  dma_ready;

    logic [BUF_ADDR_W-1:0] buf_start_addr;
    logic                  burst_out_start;
    logic                  burst_in_start;
    logic                  busy;

    modport master (
        input  rx_req_valid, rx_req_addr, rx_req_len,
        input  tx_req_valid, tx_req_addr, tx_req_len,
        input  dma_ready,
        output rx_req_ready, rx_done, tx_req_ready, tx_done,
        output dma_addr, dma_len, dma_read_not_write, dma_start,
        output buf_start_addr, burst_out_start, burst_in_start, busy
    );

    modport slave (
        output rx_req_valid, rx_req_addr, rx_req_len,
        output tx_req_valid, tx_req_addr, tx_req_len,
        output dma_ready,
        input  rx_req_ready, rx_done, tx_req_ready, tx_done,
        input  dma_addr, dma_len, dma_read_not_write, dma_start,
        input  buf_start_addr, burst_out_start, burst_in_start, busy
    );
endinterface

// File: rtl/eth_dma_scheduler.sv
// Round-robin RX/TX scheduler for the shared DMA engine; splits each request
// into chunks of at most MAX_CHUNK words and pulses a per-path done at the end.
module eth_dma_scheduler #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned BUF_ADDR_W = 11,
    parameter int unsigned MAX_CHUNK  = 256
) (
    input logic                 clk,
    input logic                 rst,
    eth_dma_scheduler_if.master bus_io
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;
    typedef enum logic {DIR_RX = 1'b0, DIR_TX = 1'b1} dir_e;

    localparam logic [LEN_W-1:0] MAX_CHUNK_L = LEN_W'(MAX_CHUNK);

    state_e                state_q, state_d;
    dir_e                  dir_q, dir_d;
    dir_e                  last_grant_q, last_grant_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic [LEN_W-1:0]      chunk_q, chunk_d;
    logic [AXI_ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [AXI_ADDR_W-1:0] dma_addr_q, dma_addr_d;
    logic [BUF_ADDR_W-1:0] buf_ptr_q, buf_ptr_d;
    logic [BUF_ADDR_W-1:0] buf_start_q, buf_start_d;
    logic                  rx_done_q, rx_done_d;
    logic                  tx_done_q, tx_done_d;

    logic                  rx_grant_c, tx_grant_c, dma_start_c;
    logic [AXI_ADDR_W-1:0] req_addr_c, addr_next_c;
    logic [LEN_W-1:0]      req_len_c, rem_next_c;
    logic [BUF_ADDR_W-1:0] buf_next_c;

    function automatic logic [LEN_W-1:0] chunk_of(input logic [LEN_W-1:0] words);
        return (words > MAX_CHUNK_L) ? MAX_CHUNK_L : words;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dir_q        <= DIR_RX;
            last_grant_q <= DIR_TX;
            remaining_q  <= '0;
            chunk_q      <= '0;
            cur_addr_q   <= '0;
            dma_addr_q   <= '0;
            buf_ptr_q    <= '0;
            buf_start_q  <= '0;
            rx_done_q    <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            last_grant_q <= last_grant_d;
            remaining_q  <= remaining_d;
            chunk_q      <= chunk_d;
            cur_addr_q   <= cur_addr_d;
            dma_addr_q   <= dma_addr_d;
            buf_ptr_q    <= buf_ptr_d;
            buf_start_q  <= buf_start_d;
            rx_done_q    <= rx_done_d;
            tx_done_q    <= tx_done_d;
        end
    end

    // Arbitration, chunk sequencing and counter updates
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        last_grant_d = last_grant_q;
        remaining_d  = remaining_q;
        chunk_d      = chunk_q;
        cur_addr_d   = cur_addr_q;
        dma_addr_d   = dma_addr_q;
        buf_ptr_d    = buf_ptr_q;
        buf_start_d  = buf_start_q;
        rx_done_d    = 1'b0;
        tx_done_d    = 1'b0;
        dma_start_c  = 1'b0;

        rx_grant_c = (state_q == IDLE) && bus_io.rx_req_valid &&
                     (!bus_io.tx_req_valid || (last_grant_q == DIR_TX));
        tx_grant_c = (state_q == IDLE) && bus_io.tx_req_valid &&
                     (!bus_io.rx_req_valid || (last_grant_q == DIR_RX));
        req_addr_c = tx_grant_c ? bus_io.tx_req_addr : bus_io.rx_req_addr;
        req_len_c  = tx_grant_c ? bus_io.tx_req_len  : bus_io.rx_req_len;

        rem_next_c  = remaining_q - chunk_q;
        addr_next_c = cur_addr_q + (AXI_ADDR_W'(chunk_q) << 2);
        buf_next_c  = buf_ptr_q + BUF_ADDR_W'(chunk_q);

        case (state_q)
            IDLE: begin
                if (rx_grant_c || tx_grant_c) begin
                    last_grant_d = tx_grant_c ? DIR_TX : DIR_RX;
                    cur_addr_d   = req_addr_c;
                    remaining_d  = req_len_c;
                    buf_ptr_d    = '0;
                    if (req_len_c == '0) begin
                        rx_done_d = rx_grant_c;
                        tx_done_d = tx_grant_c;
                    end else begin
                        // DMA-facing fields only move when a new chunk is staged
                        state_d     = ISSUE;
                        dir_d       = tx_grant_c ? DIR_TX : DIR_RX;
                        chunk_d     = chunk_of(req_len_c);
                        dma_addr_d  = req_addr_c;
                        buf_start_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (bus_io.dma_ready) begin
                    dma_start_c = 1'b1;
                    state_d     = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!bus_io.dma_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus_io.dma_ready) begin
                    remaining_d = rem_next_c;
                    cur_addr_d  = addr_next_c;
                    buf_ptr_d   = buf_next_c;
                    if (rem_next_c == '0) begin
                        rx_done_d = (dir_q == DIR_RX);
                        tx_done_d = (dir_q == DIR_TX);
                        state_d   = IDLE;
                    end else begin
                        state_d     = ISSUE;
                        chunk_d     = chunk_of(rem_next_c);
                        dma_addr_d  = addr_next_c;
                        buf_start_d = buf_next_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_io.rx_req_ready       = rx_grant_c;
    assign bus_io.tx_req_ready       = tx_grant_c;
    assign bus_io.rx_done            = rx_done_q;
    assign bus_io.tx_done            = tx_done_q;
    assign bus_io.dma_addr           = dma_addr_q;
    assign bus_io.dma_len            = chunk_q;
    assign bus_io.dma_read_not_write = (dir_q == DIR_TX);
    assign bus_io.dma_start          = dma_start_c;
    assign bus_io.buf_start_addr     = buf_start_q;
    assign bus_io.burst_out_start    = dma_start_c && (dir_q == DIR_RX);
    assign bus_io.burst_in_start     = dma_start_c && (dir_q == DIR_TX);
    assign bus_io.busy               = (state_q != IDLE);

endmodule

// File: tb/tb_eth_dma_scheduler.sv
// Directed bench for eth_dma_scheduler: request table with a DMA-engine model,
// plus arbitration, zero-length and mid-transfer reset sequences.
module tb_eth_dma_scheduler;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 16;
    localparam int unsigned BW = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_dma_scheduler_if #(.AXI_ADDR_W(AW), .LEN_W(LW), .BUF_ADDR_W(BW)) bus ();
    eth_dma_scheduler #(.AXI_ADDR_W(AW), .LEN_W(LW), .BUF_ADDR_W(BW), .MAX_CHUNK(256))
        dut (.clk(clk), .rst(rst), .bus_io(bus));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // DMA engine model and start/done log; the only writer of dma_ready
    int eng_delay = 1;
    int eng_hold  = 1;
    int eng_phase = 0;
    int eng_cnt   = 0;
    int n_st      = 0;
    int rx_done_n = 0, tx_done_n = 0, rx_done_cyc = 0, tx_done_cyc = 0;
    logic [31:0] st_addr [64];
    logic [15:0] st_len  [64];
    logic [10:0] st_buf  [64];
    logic        st_rnw  [64];
    logic        st_bo   [64];
    logic        st_bi   [64];
    int          st_cyc  [64];
    int          rise_cyc[64];

    initial begin
        bus.dma_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.dma_ready = 1'b1;
                eng_phase     = 0;
            end else if (eng_phase == 1) begin
                if (eng_cnt == 0) begin
                    bus.dma_ready = 1'b0;
                    eng_phase     = 2;
                    eng_cnt       = eng_hold - 1;
                end else eng_cnt--;
            end else if (eng_phase == 2) begin
                if (eng_cnt == 0) begin
                    bus.dma_ready = 1'b1;
                    eng_phase     = 0;
                    if (n_st > 0 && n_st <= 64) rise_cyc[n_st-1] = cyc;
                end else eng_cnt--;
            end
            #1;
            if (bus.rx_done === 1'b1) begin rx_done_n++; rx_done_cyc = cyc; end
            if (bus.tx_done === 1'b1) begin tx_done_n++; tx_done_cyc = cyc; end
            if (bus.dma_start === 1'b1) begin
                if (n_st < 64) begin
                    st_addr[n_st] = bus.dma_addr;
                    st_len[n_st]  = bus.dma_len;
                    st_buf[n_st]  = bus.buf_start_addr;
                    st_rnw[n_st]  = bus.dma_read_not_write;
                    st_bo[n_st]   = bus.burst_out_start;
                    st_bi[n_st]   = bus.burst_in_start;
                    st_cyc[n_st]  = cyc;
                end
                n_st++;
                if (eng_phase == 0) begin
                    eng_phase = 1;
                    eng_cnt   = eng_delay - 1;
                end
            end
        end
    end

    task automatic drive_req(input bit is_tx, input logic [31:0] a, input logic [15:0] l,
                             output int acc_cyc);
        bit got;
        got     = 1'b0;
        acc_cyc = -100;
        @(negedge clk); #2;
        if (is_tx) begin
            bus.tx_req_valid = 1'b1; bus.tx_req_addr = a; bus.tx_req_len = l;
        end else begin
            bus.rx_req_valid = 1'b1; bus.rx_req_addr = a; bus.rx_req_len = l;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if ((is_tx ? bus.tx_req_ready : bus.rx_req_ready) === 1'b1) begin
                got = 1'b1;
                acc_cyc = cyc;
            end else begin
                @(negedge clk); #2;
            end
        end
        chk("accept_seen", 64'(got), 64'd1);
        @(negedge clk); #2;
        bus.tx_req_valid = 1'b0;
        bus.rx_req_valid = 1'b0;
    endtask

    task automatic wait_done(input bit is_tx, input int n0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk); #3;
            if ((is_tx ? tx_done_n : rx_done_n) > n0) ok = 1'b1;
        end
    endtask

    task automatic chk_start(input string tag, input int ix, input logic [31:0] a,
                             input logic [15:0] l, input logic [10:0] b, input bit is_tx);
        chk({tag, "_addr"}, 64'(st_addr[ix]), 64'(a));
        chk({tag, "_len"},  64'(st_len[ix]),  64'(l));
        chk({tag, "_buf"},  64'(st_buf[ix]),  64'(b));
        chk({tag, "_rnw"},  64'(st_rnw[ix]),  64'(is_tx));
        chk({tag, "_bout"}, 64'(st_bo[ix]),   64'(!is_tx));
        chk({tag, "_bin"},  64'(st_bi[ix]),   64'(is_tx));
    endtask

    typedef struct {
        bit          is_tx;
        logic [31:0] addr;
        logic [15:0] len;
        int          exp_st;
        logic [15:0] exp_last;
        int          dly;
        int          hold;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int s0, rd0, td0, acc, ng, ix, last;
        bit ok;
        logic [3:0] grants;
        logic [15:0] elen;

        vecs[0] = '{1'b0, 32'h0000_0100, 16'd100,  1, 16'd100, 1, 1};
        vecs[1] = '{1'b1, 32'h0000_0000, 16'd1000, 4, 16'd232, 1, 1};
        vecs[2] = '{1'b0, 32'h0000_2000, 16'd256,  1, 16'd256, 2, 3};
        vecs[3] = '{1'b1, 32'h0000_0040, 16'd257,  2, 16'd1,   1, 2};
        vecs[4] = '{1'b0, 32'h0000_0010, 16'd300,  2, 16'd44,  3, 50};
        vecs[5] = '{1'b1, 32'hFFFF_FC00, 16'd513,  3, 16'd1,   1, 1};

        rst = 1'b1;
        bus.rx_req_valid = 1'b0; bus.rx_req_addr = '0; bus.rx_req_len = '0;
        bus.tx_req_valid = 1'b0; bus.tx_req_addr = '0; bus.tx_req_len = '0;
        repeat (3) @(negedge clk);
        #3;
        chk("reset_busy",      64'(bus.busy),           64'd0);
        chk("reset_dma_start", 64'(bus.dma_start),      64'd0);
        chk("reset_dma_len",   64'(bus.dma_len),        64'd0);
        chk("reset_dma_addr",  64'(bus.dma_addr),       64'd0);
        chk("reset_rx_done",   64'(bus.rx_done),        64'd0);
        chk("reset_tx_done",   64'(bus.tx_done),        64'd0);
        @(negedge clk); #2;
        rst = 1'b0;

        // Both requesters held valid: grants must alternate starting with RX
        eng_delay = 1; eng_hold = 1;
        s0 = n_st; rd0 = rx_done_n; td0 = tx_done_n;
        @(negedge clk); #2;
        bus.rx_req_valid = 1'b1; bus.rx_req_addr = 32'h1000; bus.rx_req_len = 16'd1;
        bus.tx_req_valid = 1'b1; bus.tx_req_addr = 32'h2000; bus.tx_req_len = 16'd1;
        #1;
        chk("arb_first_rx_ready", 64'(bus.rx_req_ready), 64'd1);
        chk("arb_first_tx_held",  64'(bus.tx_req_ready), 64'd0);
        ng = 0; grants = '0;
        for (int i = 0; i < 300 && ng < 4; i++) begin
            if (bus.rx_req_ready === 1'b1 || bus.tx_req_ready === 1'b1) begin
                chk("arb_one_hot", 64'(bus.rx_req_ready & bus.tx_req_ready), 64'd0);
                grants[ng] = bus.tx_req_ready;
                ng++;
            end
            if (ng < 4) begin @(negedge clk); #3; end
        end
        @(negedge clk); #2;
        bus.rx_req_valid = 1'b0; bus.tx_req_valid = 1'b0;
        repeat (30) @(negedge clk);
        #3;
        chk("arb_grant_count", 64'(ng), 64'd4);
        chk("arb_order",       64'(grants), 64'b1010);
        chk("arb_starts",      64'(n_st - s0), 64'd4);
        chk("arb_rx_dones",    64'(rx_done_n - rd0), 64'd2);
        chk("arb_tx_dones",    64'(tx_done_n - td0), 64'd2);
        chk_start("arb_s0", s0,     32'h1000, 16'd1, 11'd0, 1'b0);
        chk_start("arb_s1", s0 + 1, 32'h2000, 16'd1, 11'd0, 1'b1);

        // Request table
        for (int v = 0; v < 6; v++) begin
            eng_delay = vecs[v].dly; eng_hold = vecs[v].hold;
            s0 = n_st; rd0 = rx_done_n; td0 = tx_done_n;
            drive_req(vecs[v].is_tx, vecs[v].addr, vecs[v].len, acc);
            wait_done(vecs[v].is_tx, vecs[v].is_tx ? td0 : rd0, ok);
            chk($sformatf("v%0d_done_seen", v), 64'(ok), 64'd1);
            repeat (3) @(negedge clk);
            #3;
            chk($sformatf("v%0d_starts", v), 64'(n_st - s0), 64'(vecs[v].exp_st));
            for (int k = 0; k < vecs[v].exp_st && s0 + k < 64; k++) begin
                ix   = s0 + k;
                elen = (k == vecs[v].exp_st - 1) ? vecs[v].exp_last : 16'd256;
                chk_start($sformatf("v%0d_k%0d", v, k), ix, vecs[v].addr + 32'(k * 1024),
                          elen, 11'(k * 256), vecs[v].is_tx);
                if (k == 0)
                    chk($sformatf("v%0d_first_start_lat", v), 64'(st_cyc[ix] - acc), 64'd1);
                else
                    chk($sformatf("v%0d_k%0d_restart_lat", v, k),
                        64'(st_cyc[ix] - rise_cyc[ix-1]), 64'd1);
            end
            last = s0 + vecs[v].exp_st - 1;
            if (last >= 0 && last < 64)
                chk($sformatf("v%0d_done_lat", v),
                    64'((vecs[v].is_tx ? tx_done_cyc : rx_done_cyc) - rise_cyc[last]), 64'd1);
            chk($sformatf("v%0d_rx_done_cnt", v), 64'(rx_done_n - rd0), 64'(!vecs[v].is_tx));
            chk($sformatf("v%0d_tx_done_cnt", v), 64'(tx_done_n - td0), 64'(vecs[v].is_tx));
        end

        // Zero-length TX: accept, done next cycle, never busy, no DMA start
        s0 = n_st; td0 = tx_done_n; rd0 = rx_done_n;
        @(negedge clk); #2;
        bus.tx_req_valid = 1'b1; bus.tx_req_addr = 32'h500; bus.tx_req_len = 16'd0;
        #1;
        chk("zl_tx_ready", 64'(bus.tx_req_ready), 64'd1);
        chk("zl_rx_ready", 64'(bus.rx_req_ready), 64'd0);
        chk("zl_busy_acc", 64'(bus.busy),         64'd0);
        @(negedge clk); #2;
        bus.tx_req_valid = 1'b0;
        #1;
        chk("zl_tx_done",    64'(bus.tx_done), 64'd1);
        chk("zl_busy_after", 64'(bus.busy),    64'd0);
        repeat (3) @(negedge clk);
        #3;
        chk("zl_no_start",   64'(n_st - s0),        64'd0);
        chk("zl_done_count", 64'(tx_done_n - td0),  64'd1);
        chk("zl_no_rx_done", 64'(rx_done_n - rd0),  64'd0);

        // Reset asserted while the second chunk is in WAIT_DONE
        eng_delay = 1; eng_hold = 20;
        s0 = n_st; td0 = tx_done_n; rd0 = rx_done_n;
        drive_req(1'b1, 32'h4000, 16'd600, acc);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk); #3;
            if (n_st - s0 >= 2) ok = 1'b1;
        end
        chk("rst_second_start_seen", 64'(ok), 64'd1);
        repeat (3) @(negedge clk);
        #2;
        chk("rst_pre_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_busy",      64'(bus.busy),               64'd0);
        chk("rst_dma_start", 64'(bus.dma_start),          64'd0);
        chk("rst_dma_addr",  64'(bus.dma_addr),           64'd0);
        chk("rst_dma_len",   64'(bus.dma_len),            64'd0);
        chk("rst_buf_start", 64'(bus.buf_start_addr),     64'd0);
        chk("rst_rnw",       64'(bus.dma_read_not_write), 64'd0);
        chk("rst_tx_done",   64'(bus.tx_done),            64'd0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (25) @(negedge clk);
        #3;
        chk("rst_no_tx_done",   64'(tx_done_n - td0), 64'd0);
        chk("rst_no_new_start", 64'(n_st - s0),       64'd2);
        chk("rst_idle",         64'(bus.busy),        64'd0);

        eng_delay = 1; eng_hold = 1;
        s0 = n_st; rd0 = rx_done_n;
        drive_req(1'b0, 32'h300, 16'd10, acc);
        wait_done(1'b0, rd0, ok);
        chk("post_rst_done_seen", 64'(ok), 64'd1);
        repeat (2) @(negedge clk);
        #3;
        chk("post_rst_starts", 64'(n_st - s0), 64'd1);
        chk_start("post_rst", s0, 32'h300, 16'd10, 11'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
